// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_pkg
// Description : Shared constants, counter state encoding and digit helpers
//               for the two-digit BCD up-counter.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

    // Largest value a single BCD digit may hold
    localparam logic [3:0] DIGIT_MAX = 4'd9;

    // Counter state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Saturate a captured digit so the target is always a reachable count
    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max);
        return (d > max) ? max : d;
    endfunction

endpackage : timer_pkg
`default_nettype wire

// File: rtl/bcd_digit_up.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_up
// Description : Single BCD digit incrementer, 0..MAX with carry-out on wrap.
//               carry is combinational: inc asserted while digit is at MAX.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_up
    import timer_pkg::*;
#(
    parameter logic [3:0] MAX = DIGIT_MAX
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       inc,
    output logic [3:0] digit,
    output logic       carry
);

    logic [3:0] r_digit;

    // ">=" keeps the digit inside 0..MAX even if it were ever disturbed
    assign carry = inc && (r_digit >= MAX);
    assign digit = r_digit;

    // Synchronous clear wins; otherwise step and wrap to zero on carry
    always_ff @(posedge clock) begin
        if (clear) begin
            r_digit <= 4'd0;
        end else if (inc) begin
            r_digit <= carry ? 4'd0 : (r_digit + 4'd1);
        end
    end

endmodule : bcd_digit_up
`default_nettype wire

// File: rtl/bcd_upcount2.sv
`default_nettype none
// ============================================================================
// Module      : bcd_upcount2
// Description : Two-digit BCD up-counter that counts from 00 to a loaded
//               target and then holds with a registered terminal-count flag.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_upcount2
    import timer_pkg::*;
#(
    parameter int TENS_MAX = 9
) (
    input  logic       clock,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] data_ones,
    input  logic [3:0] data_tens,
    input  logic       enable,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       tc,
    output logic       zero
);

    localparam logic [3:0] c_TENS_MAX = 4'(TENS_MAX);

    logic [1:0] r_state;
    logic [3:0] r_tgt_ones;
    logic [3:0] r_tgt_tens;
    logic       r_tc;

    logic       w_step;
    logic       w_clear;
    logic       w_ones_carry;
    logic       w_tens_carry;
    logic [3:0] w_next_ones;
    logic [3:0] w_next_tens;
    logic       w_hit;
    logic [3:0] w_ld_ones;
    logic [3:0] w_ld_tens;

    // Counting only happens in RUN; reset and load take the edge instead
    assign w_step  = (r_state == ST_RUN) && enable && !load && !clr;
    assign w_clear = clr || load;

    bcd_digit_up #(.MAX(DIGIT_MAX)) u_ones (
        .clock (clock),
        .clear (w_clear),
        .inc   (w_step),
        .digit (ones),
        .carry (w_ones_carry)
    );

    bcd_digit_up #(.MAX(c_TENS_MAX)) u_tens (
        .clock (clock),
        .clear (w_clear),
        .inc   (w_ones_carry),
        .digit (tens),
        .carry (w_tens_carry)
    );

    // Value the digits will show after this edge, so tc rises with the target
    assign w_next_ones = w_ones_carry ? 4'd0 : (ones + 4'd1);
    assign w_next_tens = w_tens_carry ? 4'd0 : (w_ones_carry ? (tens + 4'd1) : tens);
    assign w_hit       = w_step && (w_next_ones == r_tgt_ones) && (w_next_tens == r_tgt_tens);

    assign w_ld_ones = clamp_digit(data_ones, DIGIT_MAX);
    assign w_ld_tens = clamp_digit(data_tens, c_TENS_MAX);

    // Control FSM: target capture, completion detection and registered tc
    always_ff @(posedge clock) begin
        if (clr) begin
            r_state    <= ST_IDLE;
            r_tgt_ones <= 4'd0;
            r_tgt_tens <= 4'd0;
            r_tc       <= 1'b0;
        end else if (load) begin
            r_tgt_ones <= w_ld_ones;
            r_tgt_tens <= w_ld_tens;
            // A 00 target is already satisfied by the restarted count
            if ((w_ld_ones == 4'd0) && (w_ld_tens == 4'd0)) begin
                r_state <= ST_DONE;
                r_tc    <= 1'b1;
            end else begin
                r_state <= ST_RUN;
                r_tc    <= 1'b0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tc <= 1'b0;
                end
                ST_RUN: begin
                    if (w_hit) begin
                        r_state <= ST_DONE;
                        r_tc    <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_tc <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tc    <= 1'b0;
                end
            endcase
        end
    end

    assign tc   = r_tc;
    assign zero = (ones == 4'd0) && (tens == 4'd0);

endmodule : bcd_upcount2
`default_nettype wire

// File: tb/tb_bcd_upcount2.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_upcount2
// Description : Self-checking bench for bcd_upcount2 (TENS_MAX = 9 and 5),
//               directed scenarios followed by randomized traffic, compared
//               against an integer-valued reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_upcount2;

    logic       clock = 1'b0;
    logic       clr = 1'b1;
    logic       load = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] data_ones = 4'd0;
    logic [3:0] data_tens = 4'd0;

    logic [3:0] ones9, tens9, ones5, tens5;
    logic       tc9, zero9, tc5, zero5;

    int ntests = 0;
    int nfail  = 0;

    // Reference model: count kept as a plain decimal number 0..99
    int m_cnt[2];
    int m_tgt[2];
    bit m_run[2];
    bit m_done[2];
    int tmax[2] = '{9, 5};

    always #5 clock = ~clock;

    bcd_upcount2 #(.TENS_MAX(9)) dut9 (
        .clock     (clock),
        .clr       (clr),
        .load      (load),
        .data_ones (data_ones),
        .data_tens (data_tens),
        .enable    (enable),
        .ones      (ones9),
        .tens      (tens9),
        .tc        (tc9),
        .zero      (zero9)
    );

    bcd_upcount2 #(.TENS_MAX(5)) dut5 (
        .clock     (clock),
        .clr       (clr),
        .load      (load),
        .data_ones (data_ones),
        .data_tens (data_tens),
        .enable    (enable),
        .ones      (ones5),
        .tens      (tens5),
        .tc        (tc5),
        .zero      (zero5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit c, input bit l, input bit e, input int t, input int o);
        clr       = c;
        load      = l;
        enable    = e;
        data_tens = 4'(t);
        data_ones = 4'(o);
    endtask

    // Apply the rules of one rising edge to the model
    task automatic model_edge();
        int t1;
        int t0;
        for (int i = 0; i < 2; i++) begin
            if (clr) begin
                m_cnt[i] = 0; m_tgt[i] = 0; m_run[i] = 0; m_done[i] = 0;
            end else if (load) begin
                t1 = (int'(data_tens) > tmax[i]) ? tmax[i] : int'(data_tens);
                t0 = (int'(data_ones) > 9) ? 9 : int'(data_ones);
                m_tgt[i]  = t1 * 10 + t0;
                m_cnt[i]  = 0;
                m_done[i] = (m_tgt[i] == 0);
                m_run[i]  = !m_done[i];
            end else if (m_run[i] && enable) begin
                m_cnt[i] = (m_cnt[i] + 1) % ((tmax[i] + 1) * 10);
                if (m_cnt[i] == m_tgt[i]) begin
                    m_done[i] = 1;
                    m_run[i]  = 0;
                end
            end
        end
    endtask

    // One clock: update model at the edge, compare 1 time unit later
    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
        chk("ones9", 32'(ones9), 32'(m_cnt[0] % 10));
        chk("tens9", 32'(tens9), 32'(m_cnt[0] / 10));
        chk("tc9",   32'(tc9),   32'(m_done[0]));
        chk("zero9", 32'(zero9), 32'(m_cnt[0] == 0));
        chk("ones5", 32'(ones5), 32'(m_cnt[1] % 10));
        chk("tens5", 32'(tens5), 32'(m_cnt[1] / 10));
        chk("tc5",   32'(tc5),   32'(m_done[1]));
        chk("zero5", 32'(zero5), 32'(m_cnt[1] == 0));
        chk("range5", 32'(tens5 <= 4'd5), 32'd1);
    endtask

    initial begin
        // Reset pulse, then idle
        drive(1, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0); repeat (3) tick();
        chk("rst_ones", 32'(ones9), 32'd0);
        chk("rst_tc",   32'(tc9),   32'd0);
        chk("rst_zero", 32'(zero9), 32'd1);

        // Target 12 with enable held high
        drive(0, 1, 1, 1, 2); tick();
        chk("t12_start", 32'(ones9), 32'd0);
        drive(0, 0, 1, 0, 0); tick();
        chk("t12_first", 32'(ones9), 32'd1);
        repeat (11) tick();
        chk("t12_tens", 32'(tens9), 32'd1);
        chk("t12_ones", 32'(ones9), 32'd2);
        chk("t12_tc",   32'(tc9),   32'd1);
        repeat (5) tick();
        chk("t12_hold", 32'(ones9), 32'd2);
        chk("t12_tc_hold", 32'(tc9), 32'd1);

        // Tens 7 clamps to 5 on the TENS_MAX=5 instance (79 vs 59)
        drive(0, 1, 1, 7, 9); tick();
        drive(0, 0, 1, 0, 0); repeat (85) tick();
        chk("t59_tens", 32'(tens5), 32'd5);
        chk("t59_ones", 32'(ones5), 32'd9);
        chk("t59_tc",   32'(tc5),   32'd1);
        chk("t79_tens", 32'(tens9), 32'd7);
        chk("t79_tc",   32'(tc9),   32'd1);

        // Enable gap at 07, then run to 34 and clear together with load
        drive(0, 1, 1, 5, 0); tick();
        drive(0, 0, 1, 0, 0); repeat (7) tick();
        chk("gap_07", 32'(ones9), 32'd7);
        drive(0, 0, 0, 0, 0); repeat (4) tick();
        chk("gap_hold", 32'(ones9), 32'd7);
        drive(0, 0, 1, 0, 0); tick();
        chk("gap_08", 32'(ones9), 32'd8);
        repeat (26) tick();
        chk("mid_tens", 32'(tens9), 32'd3);
        chk("mid_ones", 32'(ones9), 32'd4);
        drive(1, 1, 1, 2, 2); tick();
        chk("clr_cnt", 32'(ones9), 32'd0);
        chk("clr_tc",  32'(tc9),   32'd0);
        drive(0, 0, 1, 0, 0); repeat (3) tick();
        chk("idle_hold", 32'(ones9), 32'd0);

        // Target 00 finishes at once; reload from DONE restarts
        drive(0, 1, 0, 0, 0); tick();
        chk("t00_tc",   32'(tc9),   32'd1);
        chk("t00_zero", 32'(zero9), 32'd1);
        drive(0, 0, 1, 0, 0); repeat (2) tick();
        chk("t00_hold", 32'(tc9), 32'd1);
        drive(0, 1, 1, 0, 3); tick();
        chk("t03_tc",  32'(tc9),   32'd0);
        chk("t03_cnt", 32'(ones9), 32'd0);
        drive(0, 0, 1, 0, 0); repeat (3) tick();
        chk("t03_ones", 32'(ones9), 32'd3);
        chk("t03_done", 32'(tc9),   32'd1);

        // Randomized traffic, including out-of-range digits
        repeat (400) begin
            drive(($urandom % 40) == 0, ($urandom % 12) == 0, ($urandom % 4) != 0,
                  int'($urandom % 16), int'($urandom % 16));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule : tb_bcd_upcount2
`default_nettype wire
